// File: rtl/microcode_sequencer.sv
// Writable-microcode control sequencer: three fixed fetch steps, then up to USTEPS
// execute steps read from a runtime-loadable table. Emits one registered control word per clock.
module microcode_sequencer #(
    parameter int CTRL_W = 16,
    parameter int IREG_W = 8,
    parameter int OPC_W  = 4,
    parameter int USTEPS = 8,
    parameter logic [CTRL_W-1:0] F0_CTRL = '0,
    parameter logic [CTRL_W-1:0] F1_CTRL = '0,
    parameter logic [CTRL_W-1:0] F2_CTRL = '0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               en,
    input  logic                               zf,
    input  logic                               cf,
    input  logic [IREG_W-1:0]                  ireg,
    input  logic                               resume,
    input  logic                               uc_we,
    input  logic [OPC_W+$clog2(USTEPS)-1:0]    uc_addr,
    input  logic [CTRL_W+3:0]                  uc_wdata,
    output logic [CTRL_W-1:0]                  ctrl,
    output logic                               halted,
    output logic                               uc_err,
    output logic [$clog2(USTEPS)+1:0]          step
);
    localparam int UW       = $clog2(USTEPS);
    localparam int AW       = OPC_W + UW;
    localparam int EW       = CTRL_W + 4;
    localparam int UC_DEPTH = 1 << AW;
    localparam logic [UW-1:0] LAST_STEP = UW'(USTEPS - 1);
    // Entries are stored with END inverted so that an all-zero (unprogrammed) RAM reads as END-only NOPs.
    localparam logic [EW-1:0] END_MASK = {1'b1, {(EW-1){1'b0}}};

    typedef enum logic [2:0] {ST_F0, ST_F1, ST_F2, ST_EX, ST_HALT} state_t;

    state_t            state_reg, state_next;
    logic [UW-1:0]     ustep_reg, ustep_next;
    logic [CTRL_W-1:0] ctrl_reg, ctrl_next;
    logic              halted_reg, halted_next;
    logic              err_reg, err_next;

    logic [EW-1:0]     uc_mem [0:UC_DEPTH-1];
    logic [OPC_W-1:0]  opcode;
    logic [EW-1:0]     entry;
    logic              e_end, e_hlt, e_cz, e_cc, gated;
    logic              unused_ireg;

    assign opcode      = ireg[IREG_W-1 -: OPC_W];
    assign unused_ireg = ^ireg;

    // Microcode table is not reset; a write reaching the entry being executed takes effect next cycle.
    always_ff @(posedge clk) begin
        if (uc_we) begin
            uc_mem[uc_addr] <= uc_wdata ^ END_MASK;
        end
    end

    assign entry = uc_mem[{opcode, ustep_reg}] ^ END_MASK;
    assign e_end = entry[EW-1];
    assign e_hlt = entry[EW-2];
    assign e_cz  = entry[EW-3];
    assign e_cc  = entry[EW-4];
    assign gated = (e_cz & ~zf) | (e_cc & ~cf);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= ST_F0;
            ustep_reg  <= '0;
            ctrl_reg   <= '0;
            halted_reg <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            ustep_reg  <= ustep_next;
            ctrl_reg   <= ctrl_next;
            halted_reg <= halted_next;
            err_reg    <= err_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        ustep_next  = ustep_reg;
        ctrl_next   = '0;
        err_next    = err_reg;
        // halted tracks the word being issued, so it aligns with ctrl rather than with the state.
        halted_next = (state_reg == ST_HALT);
        case (state_reg)
            ST_F0: if (en) begin
                ctrl_next  = F0_CTRL;
                state_next = ST_F1;
            end
            ST_F1: if (en) begin
                ctrl_next  = F1_CTRL;
                state_next = ST_F2;
            end
            ST_F2: if (en) begin
                ctrl_next  = F2_CTRL;
                state_next = ST_EX;
                ustep_next = '0;
            end
            ST_EX: if (en) begin
                ctrl_next = gated ? '0 : entry[CTRL_W-1:0];
                if (e_hlt) begin
                    state_next = ST_HALT;
                    ustep_next = '0;
                end else if (e_end) begin
                    state_next = ST_F0;
                    ustep_next = '0;
                end else if (ustep_reg == LAST_STEP) begin
                    err_next   = 1'b1;
                    state_next = ST_F0;
                    ustep_next = '0;
                end else begin
                    ustep_next = ustep_reg + UW'(1);
                end
            end
            ST_HALT: if (en && resume) begin
                state_next = ST_F0;
                ustep_next = '0;
            end
            default: begin
                state_next = ST_F0;
                ustep_next = '0;
            end
        endcase
    end

    // Debug encoding: {phase, ustep}; HALT shows phase 0 with an all-ones step (F0 always has step 0).
    always_comb begin
        step = {2'b00, ustep_reg};
        case (state_reg)
            ST_F0:   step = {2'b00, {UW{1'b0}}};
            ST_F1:   step = {2'b01, {UW{1'b0}}};
            ST_F2:   step = {2'b10, {UW{1'b0}}};
            ST_EX:   step = {2'b11, ustep_reg};
            ST_HALT: step = {2'b00, {UW{1'b1}}};
            default: step = '0;
        endcase
    end

    assign ctrl   = ctrl_reg;
    assign halted = halted_reg;
    assign uc_err = err_reg;
endmodule

// File: tb/tb_microcode_sequencer.sv
// Scoreboard bench: stimulus pushes the expected {ctrl, halted, uc_err} for each edge,
// a negedge monitor pops and compares.
module tb_microcode_sequencer;
    localparam int CTRL_W = 16;
    localparam int IREG_W = 8;
    localparam int OPC_W  = 4;
    localparam int USTEPS = 8;
    localparam logic [15:0] MO  = 16'h0001, MAI = 16'h0002, AI  = 16'h0004, PCI = 16'h0008;
    localparam logic [15:0] PCO = 16'h0010, PCS = 16'h0020, II  = 16'h0040;
    localparam logic [15:0] F0W = PCO | MAI | PCS;
    localparam logic [15:0] F1W = MO | II;
    localparam logic [15:0] F2W = PCO | MAI | PCS | 16'h8000; // tagged to tell it apart from F0

    logic        clk, rst, en, zf, cf, resume, uc_we;
    logic [7:0]  ireg;
    logic [6:0]  uc_addr;
    logic [19:0] uc_wdata;
    logic [15:0] ctrl;
    logic        halted, uc_err;
    logic [4:0]  step;

    microcode_sequencer #(
        .CTRL_W(CTRL_W), .IREG_W(IREG_W), .OPC_W(OPC_W), .USTEPS(USTEPS),
        .F0_CTRL(F0W), .F1_CTRL(F1W), .F2_CTRL(F2W)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .zf(zf), .cf(cf), .ireg(ireg),
        .resume(resume), .uc_we(uc_we), .uc_addr(uc_addr), .uc_wdata(uc_wdata),
        .ctrl(ctrl), .halted(halted), .uc_err(uc_err), .step(step)
    );

    typedef struct packed {
        logic [15:0] c;
        logic        h;
        logic        e;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_x;
    int   checks   = 0;
    int   failures = 0;
    int   n_edge   = 0;
    logic exp_err  = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s edge=%0d actual=%h required=%h", name, n_edge, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_x = exp_q.pop_front();
            check("ctrl", 32'(ctrl), 32'(mon_x.c));
            check("halted", 32'(halted), 32'(mon_x.h));
            check("uc_err", 32'(uc_err), 32'(mon_x.e));
            $display("edge %0d: ctrl=%h halted=%0b uc_err=%0b", n_edge, ctrl, halted, uc_err);
        end
    end

    task automatic tick(input logic [15:0] c, input logic h);
        exp_t x;
        @(posedge clk);
        #1;
        n_edge++;
        x.c = c;
        x.h = h;
        x.e = exp_err;
        exp_q.push_back(x);
    endtask

    task automatic fetch(input logic [3:0] op);
        ireg = {op, 4'h0};
        tick(F0W, 1'b0);
        tick(F1W, 1'b0);
        tick(F2W, 1'b0);
    endtask

    task automatic uc_write(input logic [3:0] op, input logic [2:0] st, input logic [19:0] d);
        uc_addr  = {op, st};
        uc_wdata = d;
        uc_we    = 1'b1;
        @(posedge clk);
        #1;
        uc_we = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; en = 1'b1; zf = 1'b0; cf = 1'b0; resume = 1'b0;
        uc_we = 1'b0; ireg = 8'h00; uc_addr = '0; uc_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ctrl", 32'(ctrl), 32'h0);
        check("reset_halted", 32'(halted), 32'h0);
        check("reset_uc_err", 32'(uc_err), 32'h0);

        // Program microcode while held in reset: {END,HLT,CZ,CC,ctrl}
        uc_write(4'd1, 3'd0, {4'b0000, MO | MAI});
        uc_write(4'd1, 3'd1, {4'b1000, MO | AI});
        uc_write(4'd2, 3'd0, {4'b1010, MO | PCI});
        uc_write(4'd3, 3'd0, {4'b1001, MO | PCI});
        uc_write(4'd4, 3'd0, {4'b1100, 16'h0100});
        for (int i = 0; i < 8; i++) uc_write(4'd5, 3'(i), {4'b0000, 16'h1000 + 16'(i)});
        check("reset_hold_ctrl", 32'(ctrl), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Default microcode: every opcode is a single-step NOP
        repeat (2) begin
            fetch(4'd0);
            tick(16'h0000, 1'b0);
        end

        // LDA: two execute steps
        fetch(4'd1);
        tick(MO | MAI, 1'b0);
        tick(MO | AI, 1'b0);

        // Zero / carry conditional jumps, taken and not taken
        zf = 1'b1; fetch(4'd2); tick(MO | PCI, 1'b0);
        zf = 1'b0; fetch(4'd2); tick(16'h0000, 1'b0);
        cf = 1'b1; fetch(4'd3); tick(MO | PCI, 1'b0);
        cf = 1'b0; zf = 1'b1; fetch(4'd3); tick(16'h0000, 1'b0);
        zf = 1'b0;

        // HLT (with END also set): entry word issued, then HALT held, even across stalls
        fetch(4'd4);
        tick(16'h0100, 1'b0);
        for (int i = 0; i < 10; i++) begin
            en = (i % 3 != 1);
            tick(16'h0000, 1'b1);
        end
        resume = 1'b1; en = 1'b0;
        tick(16'h0000, 1'b1);
        en = 1'b1;
        tick(16'h0000, 1'b1);
        resume = 1'b0; ireg = 8'h10;
        tick(F0W, 1'b0);
        resume = 1'b1;
        tick(F1W, 1'b0);
        resume = 1'b0;
        tick(F2W, 1'b0);
        tick(MO | MAI, 1'b0);

        // Stall inside EX step 1: zeros while stalled, then step 1 issued exactly once
        en = 1'b0;
        repeat (3) tick(16'h0000, 1'b0);
        en = 1'b1;
        tick(MO | AI, 1'b0);

        // Asynchronous reset mid-EX, then restart cleanly at F0
        fetch(4'd1);
        tick(MO | MAI, 1'b0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("async_reset_ctrl", 32'(ctrl), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        fetch(4'd1);
        tick(MO | MAI, 1'b0);
        tick(MO | AI, 1'b0);

        // Overrun: 8 steps without END; rewrite step 3 on the edge that executes it
        fetch(4'd5);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                uc_addr  = {4'd5, 3'd3};
                uc_wdata = {4'b1000, 16'h2222};
                uc_we    = 1'b1;
            end
            if (i == 7) exp_err = 1'b1;
            tick(16'h1000 + 16'(i), 1'b0);
            uc_we = 1'b0;
        end
        fetch(4'd5);
        tick(16'h1000, 1'b0);
        tick(16'h1001, 1'b0);
        tick(16'h1002, 1'b0);
        tick(16'h2222, 1'b0);
        fetch(4'd0);
        tick(16'h0000, 1'b0);

        repeat (2) @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
